voice_sequencer: RTL and testbench
==================================

Name: voice_sequencer

Overview:
- Control-side driver for one synth voice: the producer of the pitch_increment, voice_select and gate signals that a voice consumes.
- The CPU/bus side pushes note records into a small FIFO. The sequencer plays them back to back, timed in sample ticks.
- For each note it raises gate for (duration - gap) ticks, then holds gate low for gap ticks.
- Sits between the audio register block and the voice instance. Lets firmware queue melodies without per-note interrupt timing.

Parameters:
- FIFO_DEPTH, 8, number of queued note records; must be a power of 2, minimum 2.
- DUR_W, 16, width of the duration field and the tick counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- sample_tick  input  1  one-clk pulse per audio sample; all note timing counts these pulses.
- wr_valid  input  1  note record offered.
- wr_ready  output  1  FIFO can accept a record (= not full).
- wr_pitch  input  16  pitch increment for the note.
- wr_voice  input  4  waveform select for the note.
- wr_duration  input  DUR_W  total note length in ticks.
- wr_gap  input  8  release/silence ticks at the end of the note.
- flush  input  1  abort playback and empty the FIFO.
- pitch_increment  output  16  to voice.
- voice_select  output  4  to voice.
- gate  output  1  to voice envelope.
- busy  output  1  high in any state other than IDLE.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of queued records.

Behaviour:
- Reset values: pitch_increment=0, voice_select=0, gate=0, busy=0, fifo_level=0, wr_ready=1. FSM goes to IDLE; FIFO pointers are cleared.
- Write handshake: a record is stored on a clk edge where wr_valid && wr_ready. wr_ready = (fifo_level != FIFO_DEPTH) and is combinational from the registered level. A record written in cycle N is visible to the FSM in cycle N+1.
- Same-cycle push and pop: fifo_level is unchanged.
- FSM states: IDLE, ON, OFF.
- IDLE:
  - If the FIFO is non-empty, pop the head record.
  - Register pitch/voice to the outputs on that same edge.
  - Load off_cnt = min(gap, duration) and on_cnt = duration - off_cnt.
  - Next state: ON if on_cnt>0; else OFF if off_cnt>0; else stay IDLE (duration 0 = discard, consumes 1 clk).
  - gate = 1 in the same cycle as entering ON. The pop does not wait for sample_tick.
- ON:
  - Each sample_tick decrements on_cnt.
  - When a tick takes on_cnt from 1 to 0: gate=0. Go to OFF if off_cnt>0, else chain (see below).
- OFF:
  - Each sample_tick decrements off_cnt.
  - When a tick takes off_cnt from 1 to 0, chain.
- Chain:
  - If the FIFO is non-empty, pop the next record on the same edge, applying the IDLE load rules. Back-to-back notes therefore have no dead clk beyond the gap.
  - Otherwise go to IDLE.
- Gap-free notes: a note with gap=0 followed by a queued note gives gate=1 continuously (legato). Pitch changes on the tick edge with no gate drop.
- Rests: a note with gap>=duration is a rest. gate stays 0 for duration ticks and pitch/voice still update.
- Output holding: pitch_increment and voice_select hold their last values in IDLE and OFF, so the envelope release sounds at the note pitch.
- flush (priority over everything except rst):
  - Next edge: FIFO emptied, gate=0, FSM to IDLE, counters to 0.
  - pitch/voice are held.
  - A write in the same cycle as flush is dropped.
- Reset mid-note: gate drops on the reset edge; all state returns to reset values.
- sample_tick while in IDLE is ignored.

Test Plan:
- Single note: write {pitch=0x0123, voice=2, dur=10, gap=3}, tick every 4 clk -> gate high exactly 7 ticks then low 3 ticks; pitch_increment=0x0123, voice_select=2; busy falls after the 10th tick; fifo_level 1->0 one clk after the write.
- Back-to-back: queue A{dur=4,gap=1} and B{pitch=0x0200,dur=3,gap=0} -> gate 3 ticks high, 1 low, 3 high. pitch switches to 0x0200 on the 4th tick edge. Then IDLE.
- Legato and rest: A{gap=0}, B{gap=0} -> gate never drops between them. A record with dur=5, gap=9 -> gate low 5 ticks, voice_select still updated.
- FIFO full: write 8 records with ticks stalled -> wr_ready=0 with fifo_level=8 when the FSM has not yet popped. A 9th wr_valid is not accepted. The first pop re-asserts wr_ready the next clk.
- Flush mid-note: flush during ON with 3 records queued -> next clk gate=0, busy=0, fifo_level=0, pitch held. A simultaneous write is dropped.
- Edge cases: dur=0 record -> discarded, gate never rises, next record starts within 2 clk. rst asserted during ON -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/voice_sequencer.sv
// voice_sequencer: plays queued note records back to back for one synth voice.
// Each record holds pitch, waveform select, total duration and release gap,
// all timed in sample ticks. Gate is high for (duration - gap) ticks, then low
// for the remaining gap ticks; the next queued note starts on the same edge.
module voice_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int DUR_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [15:0]                   wr_pitch,
  input  logic [3:0]                    wr_voice,
  input  logic [DUR_W-1:0]              wr_duration,
  input  logic [7:0]                    wr_gap,
  input  logic                          flush,
  output logic [15:0]                   pitch_increment,
  output logic [3:0]                    voice_select,
  output logic                          gate,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} state_t;

  state_t           state;
  logic [DUR_W-1:0] on_cnt;
  logic [DUR_W-1:0] off_cnt;

  logic [15:0]      mem_pitch [FIFO_DEPTH];
  logic [3:0]       mem_voice [FIFO_DEPTH];
  logic [DUR_W-1:0] mem_dur   [FIFO_DEPTH];
  logic [7:0]       mem_gap   [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             push;
  logic             pop;
  logic             chain;
  logic [15:0]      hd_pitch;
  logic [3:0]       hd_voice;
  logic [DUR_W-1:0] hd_dur;
  logic [7:0]       hd_gap;
  logic [DUR_W-1:0] ld_on;
  logic [DUR_W-1:0] ld_off;

  // Release length is the gap, clamped so it never exceeds the whole note.
  function automatic logic [DUR_W-1:0] clamp_gap(input logic [7:0] g,
                                                 input logic [DUR_W-1:0] d);
    logic [DUR_W+7:0] ge;
    logic [DUR_W+7:0] de;
    ge = {{DUR_W{1'b0}}, g};
    de = {8'b0, d};
    return (ge < de) ? ge[DUR_W-1:0] : d;
  endfunction

  assign wr_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign busy     = (state != IDLE);

  assign hd_pitch = mem_pitch[rd_ptr];
  assign hd_voice = mem_voice[rd_ptr];
  assign hd_dur   = mem_dur[rd_ptr];
  assign hd_gap   = mem_gap[rd_ptr];
  assign ld_off   = clamp_gap(hd_gap, hd_dur);
  assign ld_on    = hd_dur - ld_off;

  // Handshake and pop decisions; a note ending on a tick pops the next record on that edge.
  always_comb begin
    chain = 1'b0;
    if (sample_tick) begin
      if (state == ON && on_cnt == DUR_W'(1) && off_cnt == '0)
        chain = 1'b1;
      else if (state == OFF && off_cnt == DUR_W'(1))
        chain = 1'b1;
    end
    push = wr_valid && wr_ready && !flush;
    pop  = !flush && (fifo_level != '0) && ((state == IDLE) || chain);
  end

  // Record storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pitch[wr_ptr] <= wr_pitch;
      mem_voice[wr_ptr] <= wr_voice;
      mem_dur[wr_ptr]   <= wr_duration;
      mem_gap[wr_ptr]   <= wr_gap;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  // Note playback FSM with registered gate/pitch/voice; pitch/voice held on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      gate            <= 1'b0;
      on_cnt          <= '0;
      off_cnt         <= '0;
      pitch_increment <= '0;
      voice_select    <= '0;
    end else if (flush) begin
      state   <= IDLE;
      gate    <= 1'b0;
      on_cnt  <= '0;
      off_cnt <= '0;
    end else if (pop) begin
      pitch_increment <= hd_pitch;
      voice_select    <= hd_voice;
      on_cnt          <= ld_on;
      off_cnt         <= ld_off;
      if (ld_on != '0) begin
        state <= ON;
        gate  <= 1'b1;
      end else if (ld_off != '0) begin
        state <= OFF;
        gate  <= 1'b0;
      end else begin
        state <= IDLE;
        gate  <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: ;
        ON: begin
          if (sample_tick) begin
            on_cnt <= on_cnt - DUR_W'(1);
            if (on_cnt == DUR_W'(1)) begin
              gate  <= 1'b0;
              state <= (off_cnt != '0) ? OFF : IDLE;
            end
          end
        end
        OFF: begin
          if (sample_tick) begin
            off_cnt <= off_cnt - DUR_W'(1);
            if (off_cnt == DUR_W'(1)) state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          gate  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_sequencer.sv
// Testbench for voice_sequencer: directed scenarios plus randomized note lists
// checked against a note-list model that expands each record into per-tick
// (gate, voice, pitch) expectations.
module tb_voice_sequencer;

  localparam int DEPTH = 8;
  localparam int DUR_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_tick;
  logic             wr_valid;
  logic             wr_ready;
  logic [15:0]      wr_pitch;
  logic [3:0]       wr_voice;
  logic [DUR_W-1:0] wr_duration;
  logic [7:0]       wr_gap;
  logic             flush;
  logic [15:0]      pitch_increment;
  logic [3:0]       voice_select;
  logic             gate;
  logic             busy;
  logic [LW-1:0]    fifo_level;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  v;
    int          d;
    int          g;
  } rec_t;

  rec_t        recs[$];
  logic [20:0] exp_q[$];   // {gate, voice, pitch} expected before each tick

  voice_sequencer #(.FIFO_DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pitch(wr_pitch),
    .wr_voice(wr_voice), .wr_duration(wr_duration), .wr_gap(wr_gap),
    .flush(flush), .pitch_increment(pitch_increment), .voice_select(voice_select),
    .gate(gate), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rec(input logic [15:0] p, input logic [3:0] v, input int d, input int g);
    wr_pitch    = p;
    wr_voice    = v;
    wr_duration = DUR_W'(d);
    wr_gap      = 8'(g);
    wr_valid    = 1'b1;
    step();
    wr_valid    = 1'b0;
  endtask

  task automatic add_rec(input logic [15:0] p, input logic [3:0] v, input int d, input int g);
    rec_t r;
    r.p = p; r.v = v; r.d = d; r.g = g;
    recs.push_back(r);
  endtask

  // Model: each note is `duration` ticks long, the last min(gap,duration) with gate low.
  function automatic void build_expected();
    exp_q.delete();
    foreach (recs[i]) begin
      int off;
      off = (recs[i].g < recs[i].d) ? recs[i].g : recs[i].d;
      for (int k = 0; k < recs[i].d; k++)
        exp_q.push_back({(k < recs[i].d - off) ? 1'b1 : 1'b0, recs[i].v, recs[i].p});
    end
  endfunction

  task automatic push_all();
    foreach (recs[i]) push_rec(recs[i].p, recs[i].v, recs[i].d, recs[i].g);
  endtask

  // Tick through the expected list, then confirm the sequencer parks in idle.
  task automatic run_ticks(input string name, input int period);
    rec_t last;
    build_expected();
    last = recs[recs.size()-1];
    foreach (exp_q[k]) begin
      repeat (period - 1) step();
      sample_tick = 1'b1;
      total++;
      if ({gate, voice_select, pitch_increment} !== exp_q[k] || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s tick %0d: got gate/voice/pitch=%h busy=%b, need %h busy=1",
                 name, k, {gate, voice_select, pitch_increment}, busy, exp_q[k]);
      end
      step();
      sample_tick = 1'b0;
    end
    repeat (8) step();
    total++;
    if (gate !== 1'b0 || busy !== 1'b0 || fifo_level !== '0 ||
        pitch_increment !== last.p || voice_select !== last.v) begin
      bad++;
      $display("FAIL %s end: got gate=%b busy=%b level=%0d pitch=%h voice=%h, need 0 0 0 %h %h",
               name, gate, busy, fifo_level, pitch_increment, voice_select, last.p, last.v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    total++;
    if (pitch_increment !== 16'h0 || voice_select !== 4'h0 || gate !== 1'b0 ||
        busy !== 1'b0 || fifo_level !== '0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: pitch=%h voice=%h gate=%b busy=%b level=%0d ready=%b, need 0 0 0 0 0 1",
               pitch_increment, voice_select, gate, busy, fifo_level, wr_ready);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_idle_tick();
    repeat (4) begin
      sample_tick = 1'b1; step(); sample_tick = 1'b0; step();
    end
    total++;
    if (busy !== 1'b0 || gate !== 1'b0 || fifo_level !== '0) begin
      bad++;
      $display("FAIL idle_tick: busy=%b gate=%b level=%0d, need 0 0 0", busy, gate, fifo_level);
    end
  endtask

  task automatic test_single_note();
    recs.delete();
    add_rec(16'h0123, 4'd2, 10, 3);
    push_rec(16'h0123, 4'd2, 10, 3);
    total++;
    if (fifo_level !== LW'(1)) begin
      bad++;
      $display("FAIL single_level_after_write: got %0d need 1", fifo_level);
    end
    step();
    total++;
    if (fifo_level !== '0 || gate !== 1'b1 || busy !== 1'b1 || pitch_increment !== 16'h0123) begin
      bad++;
      $display("FAIL single_pop: level=%0d gate=%b busy=%b pitch=%h, need 0 1 1 0123",
               fifo_level, gate, busy, pitch_increment);
    end
    run_ticks("single", 4);
  endtask

  task automatic test_back_to_back();
    recs.delete();
    add_rec(16'h0100, 4'd1, 4, 1);
    add_rec(16'h0200, 4'd5, 3, 0);
    push_all();
    run_ticks("back_to_back", 4);
  endtask

  task automatic test_legato_rest();
    recs.delete();
    add_rec(16'h0300, 4'd1, 3, 0);
    add_rec(16'h0400, 4'd3, 2, 0);
    add_rec(16'h0500, 4'd7, 5, 9);
    push_all();
    run_ticks("legato_rest", 4);
  endtask

  task automatic test_fifo_full();
    push_rec(16'h0A00, 4'd1, 5, 0);
    step();
    for (int i = 0; i < DEPTH; i++) push_rec(16'(i), 4'(i), 3, 1);
    total++;
    if (fifo_level !== LW'(DEPTH) || wr_ready !== 1'b0 || gate !== 1'b1) begin
      bad++;
      $display("FAIL full: level=%0d ready=%b gate=%b, need %0d 0 1", fifo_level, wr_ready, gate, DEPTH);
    end
    push_rec(16'hFFFF, 4'hF, 7, 0);
    total++;
    if (fifo_level !== LW'(DEPTH)) begin
      bad++;
      $display("FAIL full_reject: level=%0d need %0d", fifo_level, DEPTH);
    end
    for (int t = 0; t < 5; t++) begin
      step();
      sample_tick = 1'b1; step(); sample_tick = 1'b0;
    end
    total++;
    if (fifo_level !== LW'(DEPTH - 1) || wr_ready !== 1'b1 || pitch_increment !== 16'h0000) begin
      bad++;
      $display("FAIL full_pop: level=%0d ready=%b pitch=%h, need %0d 1 0000",
               fifo_level, wr_ready, pitch_increment, DEPTH - 1);
    end
    flush = 1'b1; step(); flush = 1'b0;
    total++;
    if (fifo_level !== '0 || busy !== 1'b0 || gate !== 1'b0) begin
      bad++;
      $display("FAIL full_flush: level=%0d busy=%b gate=%b, need 0 0 0", fifo_level, busy, gate);
    end
  endtask

  task automatic test_flush();
    push_rec(16'hABCD, 4'd9, 20, 2);
    step();
    push_rec(16'h1000, 4'd1, 4, 1);
    push_rec(16'h2000, 4'd2, 4, 1);
    push_rec(16'h3000, 4'd3, 4, 1);
    wr_pitch = 16'h7777; wr_voice = 4'd7; wr_duration = DUR_W'(5); wr_gap = 8'd0;
    wr_valid = 1'b1; flush = 1'b1;
    step();
    wr_valid = 1'b0; flush = 1'b0;
    total++;
    if (gate !== 1'b0 || busy !== 1'b0 || fifo_level !== '0 ||
        pitch_increment !== 16'hABCD || voice_select !== 4'd9) begin
      bad++;
      $display("FAIL flush: gate=%b busy=%b level=%0d pitch=%h voice=%h, need 0 0 0 abcd 9",
               gate, busy, fifo_level, pitch_increment, voice_select);
    end
    repeat (3) step();
    total++;
    if (busy !== 1'b0 || fifo_level !== '0 || pitch_increment !== 16'hABCD) begin
      bad++;
      $display("FAIL flush_write_dropped: busy=%b level=%0d pitch=%h, need 0 0 abcd",
               busy, fifo_level, pitch_increment);
    end
  endtask

  task automatic test_dur_zero();
    push_rec(16'h1111, 4'd4, 0, 0);
    push_rec(16'h2222, 4'd6, 2, 0);
    total++;
    if (gate !== 1'b0 || busy !== 1'b0 || pitch_increment !== 16'h1111) begin
      bad++;
      $display("FAIL dur0_discard: gate=%b busy=%b pitch=%h, need 0 0 1111", gate, busy, pitch_increment);
    end
    step();
    total++;
    if (gate !== 1'b1 || pitch_increment !== 16'h2222 || voice_select !== 4'd6) begin
      bad++;
      $display("FAIL dur0_next: gate=%b pitch=%h voice=%h, need 1 2222 6", gate, pitch_increment, voice_select);
    end
    repeat (2) begin
      step(); sample_tick = 1'b1; step(); sample_tick = 1'b0;
    end
    step();
    total++;
    if (busy !== 1'b0 || gate !== 1'b0) begin
      bad++;
      $display("FAIL dur0_end: busy=%b gate=%b, need 0 0", busy, gate);
    end
  endtask

  task automatic test_reset_mid_note();
    push_rec(16'h5555, 4'd3, 10, 2);
    step();
    repeat (2) begin
      sample_tick = 1'b1; step(); sample_tick = 1'b0; step();
    end
    push_rec(16'h6666, 4'd2, 4, 0);
    total++;
    if (gate !== 1'b1 || fifo_level !== LW'(1)) begin
      bad++;
      $display("FAIL rst_mid_pre: gate=%b level=%0d, need 1 1", gate, fifo_level);
    end
    rst = 1'b1;
    step();
    total++;
    if (pitch_increment !== 16'h0 || voice_select !== 4'h0 || gate !== 1'b0 ||
        busy !== 1'b0 || fifo_level !== '0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid: pitch=%h voice=%h gate=%b busy=%b level=%0d ready=%b, need 0 0 0 0 0 1",
               pitch_increment, voice_select, gate, busy, fifo_level, wr_ready);
    end
    rst = 1'b0;
    repeat (2) step();
    total++;
    if (busy !== 1'b0 || fifo_level !== '0) begin
      bad++;
      $display("FAIL rst_mid_after: busy=%b level=%0d, need 0 0", busy, fifo_level);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int n;
      recs.delete();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        int d;
        d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
        add_rec(16'($urandom), 4'($urandom), d, $urandom_range(0, 15));
      end
      push_all();
      repeat (8) step();
      run_ticks("random", 8);
    end
  endtask

  initial begin
    rst = 1'b1; sample_tick = 1'b0; wr_valid = 1'b0; flush = 1'b0;
    wr_pitch = '0; wr_voice = '0; wr_duration = '0; wr_gap = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
    test_reset();
    test_idle_tick();
    test_single_note();
    test_back_to_back();
    test_legato_rest();
    test_fifo_full();
    test_flush();
    test_dur_zero();
    test_reset_mid_note();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
